// File: rtl/multiplier_pkg.sv
// Shared widths, product type and latency for the 32x32 multiplier.
// Latency depends on the MULTIPLIER_PIPE_EN macro (2 when defined, else 1).
package multiplier_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef logic [PROD_W-1:0] prod_t;

`ifdef MULTIPLIER_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

  // Bit 32 carries the sign only in signed mode, so one signed 33x33 multiply covers both modes.
  function automatic logic signed [OP_W:0] extend_op(input logic [OP_W-1:0] v, input logic symbol);
    return {symbol & v[OP_W-1], v};
  endfunction

endpackage

// File: rtl/mult_pp_array.sv
// Combinational partial-product generation: splits the extended multiplier into a
// 16-bit unsigned low half and a 17-bit signed high half, giving two 64-bit partial sums.
module mult_pp_array
  import multiplier_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            symbol,
  output prod_t           pp_lo,
  output prod_t           pp_hi
);

  logic signed [OP_W:0] a_ext;
  logic signed [OP_W:0] b_ext;
  logic signed [49:0]   a_w;
  logic signed [49:0]   b_lo_w;
  logic signed [49:0]   b_hi_w;
  logic signed [49:0]   p_lo;
  logic signed [49:0]   p_hi;

  assign a_ext = extend_op(a, symbol);
  assign b_ext = extend_op(b, symbol);

  // Each 33x17 signed product fits exactly in 50 bits, so truncating to 50 loses nothing.
  assign a_w    = {{17{a_ext[OP_W]}}, a_ext};
  assign b_lo_w = {34'b0, b_ext[15:0]};
  assign b_hi_w = {{33{b_ext[OP_W]}}, b_ext[OP_W:16]};

  assign p_lo = a_w * b_lo_w;
  assign p_hi = a_w * b_hi_w;

  assign pp_lo = {{14{p_lo[49]}}, p_lo};
  assign pp_hi = {p_hi[47:0], 16'b0};

endmodule

// File: rtl/multiplier.sv
// Fully pipelined 32x32 -> 64 multiplier, unsigned or signed per operation via symbol.
// Defining MULTIPLIER_PIPE_EN registers the partial sums before the final add (latency 2).
module multiplier
  import multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              symbol,
  output logic              out_valid,
  output logic [PROD_W-1:0] o
);

  prod_t pp_lo;
  prod_t pp_hi;

  mult_pp_array u_pp (
    .a      (a),
    .b      (b),
    .symbol (symbol),
    .pp_lo  (pp_lo),
    .pp_hi  (pp_hi)
  );

`ifdef MULTIPLIER_PIPE_EN
  prod_t pp_lo_p1;
  prod_t pp_hi_p1;
  logic  vld_p1;
  prod_t o_p2;
  logic  vld_p2;

  // p0 -> p1: capture partial sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pp_lo_p1 <= '0;
      pp_hi_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        pp_lo_p1 <= pp_lo;
        pp_hi_p1 <= pp_hi;
      end
    end
  end

  // p1 -> p2: final add into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      o_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) o_p2 <= pp_lo_p1 + pp_hi_p1;
    end
  end

  assign out_valid = vld_p2;
  assign o         = o_p2;
`else
  prod_t o_p1;
  logic  vld_p1;

  // p0 -> p1: final add into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      o_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) o_p1 <= pp_lo + pp_hi;
    end
  end

  assign out_valid = vld_p1;
  assign o         = o_p1;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Randomized self-checking bench for multiplier against a plain-arithmetic product model.
module tb_multiplier;
  import multiplier_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        symbol = 1'b0;
  logic        out_valid;
  logic [63:0] o;

  always #5 clk = ~clk;

  multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .symbol    (symbol),
    .out_valid (out_valid),
    .o         (o)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] p;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] last_o = '0;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
    end else begin
      sx = {32'b0, x};
      sy = {32'b0, y};
    end
    return sx * sy;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: each accepted operation becomes an expected product due LATENCY cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last_o = '0;
    end else begin
      cyc++;
      if (in_valid) q.push_back('{ref_prod(a, b, symbol), cyc + LATENCY - 1});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_o", o, 64'd0);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        check("latency", 64'(cyc), 64'(q[0].due));
        check("product", o, q[0].p);
        last_o = q[0].p;
        void'(q.pop_front());
      end
    end else begin
      check("hold_o", o, last_o);
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_out_valid", {63'b0, out_valid}, 64'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic run_directed(input string name, input logic [31:0] x, input logic [31:0] y,
                              input logic s, input logic [63:0] req);
    int waited;
    logic got;
    @(posedge clk);
    #1 a = x; b = y; symbol = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    symbol = ~s;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    check({name, "_valid"}, {63'b0, got}, 64'd1);
    if (got) begin
      check({name, "_lat"}, 64'(waited + 1), 64'(LATENCY));
      check(name, o, req);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Pin the model itself to hand-computed products.
    check("model_025", ref_prod(32'hFA4B7D9F, 32'h11111111, 1'b0), 64'h10AFB30A_88E9E68F);
    check("model_026", ref_prod(32'hFA4B7D9F, 32'h11111111, 1'b1), 64'hFF9EA1F9_88E9E68F);
    check("model_027s", ref_prod(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
    check("model_ffu", ref_prod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE_00000001);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_o", o, 64'd0);
    rst = 1'b0;

    run_directed("unsigned_025", 32'hFA4B7D9F, 32'h11111111, 1'b0, 64'h10AFB30A_88E9E68F);
    run_directed("signed_026", 32'hFA4B7D9F, 32'h11111111, 1'b1, 64'hFF9EA1F9_88E9E68F);
    run_directed("mixed_s_027", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
    run_directed("mixed_u_027", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h7FFFFFFF_80000000);
    run_directed("ones_u", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run_directed("ones_s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
    run_directed("min_u", 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000);
    run_directed("min_s", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);

    // Back-to-back stream of random operations.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 a = $urandom; b = $urandom; symbol = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Gappy stream exercising hold behaviour.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 a = $urandom; b = $urandom; symbol = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Reset with operations in flight.
    #1 a = $urandom; b = $urandom; symbol = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 a = $urandom; b = $urandom; symbol = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_o", o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("post_rst_o", o, 64'd0);

    run_directed("after_rst", 32'h00012345, 32'hFFFF0000, 1'b1, 64'hFFFFFFFE_DCBB0000);
    repeat (4) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit; the single clock; all registers update on its rising edge.
REQ-003 Port `rst`: input, 1 bit; asynchronous, active-high reset.
REQ-004 Port `in_valid`: input, 1 bit; a, b and symbol are sampled this cycle.
REQ-005 Port `a`: input, 32 bits; multiplicand.
REQ-006 Port `b`: input, 32 bits; multiplier.
REQ-007 Port `symbol`: input, 1 bit; 0 = unsigned x unsigned, 1 = signed x signed (two's complement).
REQ-008 Port `out_valid`: output, 1 bit; `o` holds a new product this cycle.
REQ-009 Port `o`: output, 64 bits; full-width product.

Function
REQ-010 `o` SHALL equal the exact 64-bit product of a and b: zero-extended operands when symbol=0, sign-extended operands when symbol=1; no truncation, no saturation.
REQ-011 Implementation SHALL extend each operand to 33 bits (bit 32 = symbol & msb) and form a signed 33x33 product; only the low 64 bits go to `o`.
REQ-012 The pipeline SHALL be fully pipelined: one new operation accepted per cycle, no stall, no backpressure, no ready signal.
REQ-013 Latency without PIPE: `o` and `out_valid` SHALL be registered, valid exactly 1 cycle after the in_valid cycle.
REQ-014 out_valid SHALL be the in_valid bit delayed by the pipeline latency; it SHALL pulse once per accepted operation.
REQ-015 When in_valid=0, `o` SHALL hold its last value; out_valid SHALL deassert.
REQ-016 symbol SHALL be sampled with a and b and travel with that operation; a symbol change SHALL never affect an in-flight result.
REQ-017 Boundary cases SHALL be exact:
  - 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE_00000001 (unsigned) and 0x00000000_00000001 (signed).
  - 0x80000000 x 0x80000000 gives 0x40000000_00000000 in both modes.

Reset
REQ-018 Asserting `rst` SHALL immediately clear out_valid, `o` and all pipeline registers, including any valid bits.
REQ-019 An operation in flight when `rst` asserts SHALL be discarded and SHALL never produce out_valid.
REQ-020 The first operation SHALL be accepted on the first rising clk edge after `rst` deasserts.

Configuration
REQ-021 Macro MULTIPLIER_PIPE_EN, when defined, SHALL add one register stage of partial-product sums between operand capture and the final add.
  - Latency SHALL become 2 cycles; throughput and results are unchanged.
REQ-022 Without MULTIPLIER_PIPE_EN, latency SHALL be 1 cycle with a single output register stage.

Structure
REQ-023 Package multiplier_pkg SHALL hold:
  - constants OP_W=32 and PROD_W=64;
  - a typedef for the 64-bit product;
  - the latency constant, whose value depends on MULTIPLIER_PIPE_EN.
REQ-024 Partial-product generation and reduction SHALL live in one combinational sub-module, mult_pp_array.
  - It produces two 64-bit partial sums; the top level adds them and registers the result.

Verification
REQ-025 Unsigned case: a=0xFA4B7D9F, b=0x11111111, symbol=0 -> o=0x10AFB30A_88E9E68F with out_valid after LATENCY cycles.
REQ-026 Signed case: same a and b, symbol=1 -> o=0xFF9EA1F9_88E9E68F.
REQ-027 Signed mixed-sign case: a=0x80000000, b=0xFFFFFFFF, symbol=1 -> o=0x00000000_80000000; with symbol=0 -> o=0x7FFFFFFF_80000000.
REQ-028 Back-to-back streaming: drive 1000 random {a, b, symbol} on consecutive cycles with in_valid=1 -> each result matches the reference model, in order, one per cycle.
REQ-029 Reset mid-stream: assert `rst` with 2 operations in flight -> out_valid=0 and o=0 at once; no stale results after release.
REQ-030 Run REQ-025 to REQ-029 both with and without MULTIPLIER_PIPE_EN -> out_valid latency is 2 cycles and 1 cycle respectively.
